// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Optional parity is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int   UART_BAUD_DIV_DEFAULT = 2604;
    localparam logic UART_IDLE_LVL         = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small power-of-two FIFO feeding the UART transmitter.
// Count and full flag are registered; a write while full is dropped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              full_q;
    logic              push;

    // Acceptance uses the pre-edge full flag, even on a pop cycle.
    assign push  = wr_en && !full_q;
    assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO, frame FSM, baud/bit counters.
// Parity bit is inserted only when UART_TX_PARITY_EN is defined.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              TX,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              ovf
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_tx_state_t    state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              tx_q;
    logic              done_q;
    logic              ovf_q;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              bit_end;
    logic              pop;

`ifdef UART_TX_PARITY_EN
    logic              par_q;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    assign bit_end = (state_q != IDLE) && (baud_q == BAUD_LAST);
    // Pop from IDLE or at the very end of the last stop bit (no idle gap).
    assign pop = !empty && ((state_q == IDLE) ||
                 (state_q == STOP && bit_end && bit_q == STOP_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LVL;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (wr_en && full) ovf_q <= 1'b1;
            baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    tx_q <= UART_IDLE_LVL;
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_q <= par_q;
                    if (bit_end) begin
                        state_q <= STOP;
                        bit_q   <= '0;
                    end
                end
`endif
                STOP: begin
                    tx_q <= UART_IDLE_LVL;
                    if (bit_end) begin
                        if (bit_q == STOP_LAST) begin
                            done_q  <= 1'b1;
                            bit_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= UART_IDLE_LVL;
                    state_q <= IDLE;
                end
            endcase
            if (pop) begin
                shift_q <= rd_data;
                bit_q   <= '0;
                state_q <= START;
`ifdef UART_TX_PARITY_EN
                par_q   <= (^rd_data) ^ PARITY_ODD;
`endif
            end
        end
    end

    assign TX      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;
    assign ovf     = ovf_q;

endmodule
